reg_scan_ctrl: RTL and testbench
================================

# reg_scan_ctrl

Board-level debug controller between the board clock/buttons, the Tomasulo core and the display path. After reset it holds the core in reset for a set number of cycles and waits for the core's `done`. It then steps a register-file read address at one of two selectable rates, or manually while paused. It drives a selectable LED-wide page of the returned register data to the LEDs.

## Interface
- `NUM_REGS`, 32: registers scanned; `AW = $clog2(NUM_REGS)`.
- `DATA_W`, 32: register data width; must be a multiple of `LED_W`.
- `LED_W`, 16: LED count; `PAGES = DATA_W/LED_W`; `PW = max(1,$clog2(PAGES))`.
- `RST_CYCLES`, 4: core reset pulse length in cycles (≥1).
- `SLOW_DIV`, 1_000_000: cycles per step, slow rate (≥2).
- `FAST_DIV`, 250_000: cycles per step, fast rate (≥2).

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-low.
- `btn_fast`  in  1  level; 1 selects `FAST_DIV`. Synchronized and debounced upstream.
- `btn_pause`  in  1  level; 1 requests pause.
- `btn_step`  in  1  level; each rising edge steps once while paused.
- `page_sel`  in  PW  selects which LED-wide slice of `reg_data` is shown.
- `core_done`  in  1  core completion flag.
- `reg_data`  in  DATA_W  register read data for `reg_addr`; combinational from the core.
- `core_reset`  out  1  active-high reset to the core.
- `reg_addr`  out  AW  register read address.
- `led`  out  LED_W  displayed slice.
- `scan_tick`  out  1  one-cycle pulse on each address advance.
- `scan_state`  out  2  current FSM state, for debug.

## Operation
FSM states, encoded in the `scan_state` port:
- `S_RESET` (0): `core_reset`=1; counter runs `RST_CYCLES` cycles, then goes to `S_WAIT`.
- `S_WAIT` (1): `core_reset`=0; holds the address. When `core_done`=1: goes to `S_PAUSE` if `btn_pause`=1, else `S_RUN`.
- `S_RUN` (2): prescaler runs with terminal count `DIV-1`, where `DIV = btn_fast ? FAST_DIV : SLOW_DIV`.
  - At terminal count: `reg_addr` increments and `scan_tick` pulses.
  - `btn_pause`=1 goes to `S_PAUSE`.
- `S_PAUSE` (3): prescaler held at 0. A rising edge of `btn_step` increments `reg_addr` and pulses `scan_tick`. `btn_pause`=0 goes to `S_RUN`.

Rules:
- Address wraps from `NUM_REGS-1` to 0. This holds for non-power-of-two `NUM_REGS`.
- `core_done` falling in `S_RUN` or `S_PAUSE` goes to `S_WAIT`; the address is held and the prescaler cleared.
- A change of `btn_fast` clears the prescaler that cycle; no step occurs that cycle.
- Pause wins: if `btn_pause`=1 in the cycle of terminal count, there is no advance and the next state is `S_PAUSE`.
- A `btn_step` edge in any state other than `S_PAUSE` is ignored. The step edge detector keeps updating in all states, so a step button already held on entry to `S_PAUSE` does not step.
- `led <= reg_data[page_sel*LED_W +: LED_W]` every cycle. If `page_sel ≥ PAGES`, `led <= 0`.

## Timing
- Reset values while `reset`=0: `core_reset`=1, `reg_addr`=0, `led`=0, `scan_tick`=0, `scan_state`=`S_RESET`, prescaler=0, step edge register=0.
- Reset asserted mid-operation returns all of the above immediately (asynchronous).
- After `reset` deasserts, `core_reset` stays 1 for exactly `RST_CYCLES` rising edges. The first edge at which `core_done` is sampled is the edge where `core_reset` falls.
- Step period in `S_RUN` is exactly `DIV` cycles. The first step comes `DIV` cycles after entering `S_RUN`.
- `reg_addr` and `scan_tick` change on the same edge; `scan_tick` is high for exactly one cycle.
- Manual step: the address changes on the edge after the sampled rising edge of `btn_step`, a one-cycle latency.
- `led` is registered: it reflects `reg_data`/`page_sel` sampled at the previous edge.
- All outputs are registered.

## Structure
- Package `dbg_pkg`:
  - `typedef enum logic [1:0] {S_RESET, S_WAIT, S_RUN, S_PAUSE} scan_state_t`.
  - Default rate constants `DBG_SLOW_DIV` and `DBG_FAST_DIV`.
- Sub-module `tick_prescaler` (parameters `SLOW_DIV`, `FAST_DIV`; inputs `enable`, `fast`, `clear`; output `tick`):
  - Counter width `$clog2(max(SLOW_DIV,FAST_DIV))`.
  - Clears internally on a change of `fast`.
- Top level holds the FSM, the reset counter, the step edge detector, the address counter and the LED mux.

## Test plan
Bench parameters: `NUM_REGS=5`, `DATA_W=32`, `LED_W=16`, `RST_CYCLES=3`, `SLOW_DIV=8`, `FAST_DIV=2`.
- Reset release, `core_done`=1: `core_reset`=1 for exactly 3 edges, then `S_RUN`. First `scan_tick` 8 cycles later with `reg_addr`=1. Ticks then every 8 cycles.
- `btn_fast`=1 in run: ticks every 2 cycles. Address sequence 1,2,3,4,0,1 (wrap at 5).
- `btn_pause`=1 coincident with terminal count: no advance, `scan_state`=3. Then three `btn_step` pulses give three ticks, addresses +3. `btn_step` held high gives only one advance.
- `reg_data`=32'hDEAD_BEEF: `page_sel`=0 gives `led`=16'hBEEF one cycle later; `page_sel`=1 gives 16'hDEAD.
- `core_done` drops in `S_RUN` at `reg_addr`=2: `S_WAIT`, address stays 2, no ticks. `core_done` rises again: the next tick is a full 8 cycles later.
- `reset` asserted mid-`S_RUN`: all outputs immediately take their reset values, and the 3-cycle `core_reset` pulse repeats after release.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types and default rates for the board debug scan controller.
package dbg_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_WAIT  = 2'd1,
        S_RUN   = 2'd2,
        S_PAUSE = 2'd3
    } scan_state_t;

    // Default step rates for a board clock in the tens of MHz.
    localparam int DBG_SLOW_DIV = 1_000_000;
    localparam int DBG_FAST_DIV = 250_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Rate prescaler: one-cycle tick every SLOW_DIV or FAST_DIV enabled cycles.
module tick_prescaler
    import dbg_pkg::*;
#(
    parameter int SLOW_DIV = DBG_SLOW_DIV,
    parameter int FAST_DIV = DBG_FAST_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic fast,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(max_int(SLOW_DIV, FAST_DIV));
    localparam logic [CW-1:0] SLOW_TC = CW'(SLOW_DIV - 1);
    localparam logic [CW-1:0] FAST_TC = CW'(FAST_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_fast_prev;
    logic          w_fast_chg;
    logic          w_tc;

    // Terminal-count detect; a rate change suppresses the tick in that cycle.
    always_comb begin
        w_fast_chg = fast ^ r_fast_prev;
        w_tc       = fast ? (r_cnt == FAST_TC) : (r_cnt == SLOW_TC);
        tick       = enable & w_tc & ~w_fast_chg;
    end

    // Counter restarts from 0 when idle, cleared, on rate change or after a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_fast_prev <= 1'b0;
        end else begin
            r_fast_prev <= fast;
            if (!enable || clear || w_fast_chg || w_tc)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reg_scan_ctrl.sv
// Board debug controller: core reset sequencing, register-file address
// scanning (timed or manual step) and LED page display of the read data.
module reg_scan_ctrl
    import dbg_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DATA_W     = 32,
    parameter int LED_W      = 16,
    parameter int RST_CYCLES = 4,
    parameter int SLOW_DIV   = DBG_SLOW_DIV,
    parameter int FAST_DIV   = DBG_FAST_DIV,
    localparam int AW        = $clog2(NUM_REGS),
    localparam int PAGES     = DATA_W / LED_W,
    localparam int PW        = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_fast,
    input  logic              btn_pause,
    input  logic              btn_step,
    input  logic [PW-1:0]     page_sel,
    input  logic              core_done,
    input  logic [DATA_W-1:0] reg_data,
    output logic              core_reset,
    output logic [AW-1:0]     reg_addr,
    output logic [LED_W-1:0]  led,
    output logic              scan_tick,
    output logic [1:0]        scan_state
);

    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [AW-1:0]  ADDR_LAST = AW'(NUM_REGS - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_next;
    logic [RCW-1:0]   r_rst_cnt;
    logic             r_step_q;
    logic             r_step_q2;
    logic             w_step_rise;
    logic             w_tick;
    logic             w_pre_en;
    logic             w_pre_clr;
    logic             w_adv;
    logic [AW-1:0]    r_addr;
    logic             r_core_reset;
    logic             r_scan_tick;
    logic [LED_W-1:0] r_led;
    logic [LED_W-1:0] w_led;

    assign core_reset = r_core_reset;
    assign reg_addr   = r_addr;
    assign led        = r_led;
    assign scan_tick  = r_scan_tick;
    assign scan_state = r_state;

    // Prescaler only counts in RUN and restarts from 0 whenever RUN is left.
    assign w_pre_en  = (r_state == S_RUN);
    assign w_pre_clr = (w_state_next != S_RUN);

    tick_prescaler #(
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (reset),
        .enable (w_pre_en),
        .fast   (btn_fast),
        .clear  (w_pre_clr),
        .tick   (w_tick)
    );

    // Step edge is taken from a registered copy, giving one cycle of latency.
    assign w_step_rise = r_step_q & ~r_step_q2;

    // Next-state and address-advance decision.
    always_comb begin
        w_state_next = r_state;
        w_adv        = 1'b0;
        case (r_state)
            S_RESET: begin
                // The last reset-pulse edge is also the first edge that
                // samples core_done, so a finished core skips WAIT.
                if (r_rst_cnt == RST_LAST) begin
                    if (core_done)
                        w_state_next = btn_pause ? S_PAUSE : S_RUN;
                    else
                        w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_done)
                    w_state_next = btn_pause ? S_PAUSE : S_RUN;
            end
            S_RUN: begin
                if (!core_done)
                    w_state_next = S_WAIT;
                else if (btn_pause)
                    w_state_next = S_PAUSE;
                else
                    w_adv = w_tick;
            end
            S_PAUSE: begin
                if (!core_done) begin
                    w_state_next = S_WAIT;
                end else begin
                    if (!btn_pause)
                        w_state_next = S_RUN;
                    w_adv = w_step_rise;
                end
            end
            default: w_state_next = S_RESET;
        endcase
    end

    // LED page mux; out-of-range pages show nothing.
    always_comb begin
        w_led = '0;
        for (int p = 0; p < PAGES; p++) begin
            if (page_sel == PW'(p))
                w_led = reg_data[p*LED_W +: LED_W];
        end
    end

    // State register and core reset pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_RESET;
            r_rst_cnt    <= '0;
            r_core_reset <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_rst_cnt    <= (r_state == S_RESET) ? r_rst_cnt + 1'b1 : '0;
            r_core_reset <= (w_state_next == S_RESET);
        end
    end

    // Step button history, updated in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step_q  <= 1'b0;
            r_step_q2 <= 1'b0;
        end else begin
            r_step_q  <= btn_step;
            r_step_q2 <= r_step_q;
        end
    end

    // Address counter with wrap at NUM_REGS, and its advance pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_scan_tick <= 1'b0;
        end else begin
            r_scan_tick <= w_adv;
            if (w_adv)
                r_addr <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
        end
    end

    // Registered LED output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_led <= '0;
        else
            r_led <= w_led;
    end

endmodule

// File: tb/tb_reg_scan_ctrl.sv
// Directed bench for reg_scan_ctrl with small rates and a 5-entry register file.
module tb_reg_scan_ctrl;

    localparam int NUM_REGS   = 5;
    localparam int DATA_W     = 32;
    localparam int LED_W      = 16;
    localparam int RST_CYCLES = 3;
    localparam int SLOW_DIV   = 8;
    localparam int FAST_DIV   = 2;
    localparam logic [15:0] B = 16'hBEEF;
    localparam logic [15:0] D = 16'hDEAD;

    logic              clk = 1'b0;
    logic              reset;
    logic              btn_fast;
    logic              btn_pause;
    logic              btn_step;
    logic [0:0]        page_sel;
    logic              core_done;
    logic [DATA_W-1:0] reg_data;
    logic              core_reset;
    logic [2:0]        reg_addr;
    logic [LED_W-1:0]  led;
    logic              scan_tick;
    logic [1:0]        scan_state;

    always #5 clk = ~clk;

    reg_scan_ctrl #(
        .NUM_REGS   (NUM_REGS),
        .DATA_W     (DATA_W),
        .LED_W      (LED_W),
        .RST_CYCLES (RST_CYCLES),
        .SLOW_DIV   (SLOW_DIV),
        .FAST_DIV   (FAST_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_fast   (btn_fast),
        .btn_pause  (btn_pause),
        .btn_step   (btn_step),
        .page_sel   (page_sel),
        .core_done  (core_done),
        .reg_data   (reg_data),
        .core_reset (core_reset),
        .reg_addr   (reg_addr),
        .led        (led),
        .scan_tick  (scan_tick),
        .scan_state (scan_state)
    );

    typedef struct {
        int          n;
        logic        fast, pause, step, done, page;
        logic        cr;
        logic [2:0]  addr;
        logic        tick;
        logic [1:0]  st;
        logic [15:0] led;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input int n, input logic f, input logic p, input logic s,
                                input logic d, input logic pg, input logic cr, input int a,
                                input logic t, input int st, input logic [15:0] l);
        vec_t v;
        v.n = n; v.fast = f; v.pause = p; v.step = s; v.done = d; v.page = pg;
        v.cr = cr; v.addr = 3'(a); v.tick = t; v.st = 2'(st); v.led = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic cr, input logic [2:0] a,
                           input logic t, input logic [1:0] st, input logic [15:0] l);
        chk({tag, ".core_reset"}, 32'(core_reset), 32'(cr));
        chk({tag, ".reg_addr"},   32'(reg_addr),   32'(a));
        chk({tag, ".scan_tick"},  32'(scan_tick),  32'(t));
        chk({tag, ".scan_state"}, 32'(scan_state), 32'(st));
        chk({tag, ".led"},        32'(led),        32'(l));
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        //             n  f  p  s  d  pg  cr a  t  st led
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, B));  // edge 1
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, B));  // edge 2
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 2, B));  // edge 3: RUN
        vecs.push_back(mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 2, B));  // edge 10
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 2, B));  // edge 11: first tick
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 2, B));
        vecs.push_back(mk(6, 0, 0, 0, 1, 0, 0, 1, 0, 2, B));  // edge 18
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 2, 1, 2, B));  // edge 19
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 2, 0, 2, D));  // page 1
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 2, 0, 2, B));  // fast change clears
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 2, 0, 2, B));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 3, 1, 2, B));
        vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 4, 1, 2, B));
        vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 0, 1, 2, B));  // wrap
        vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 1, 1, 2, B));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 2, B));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1, 0, 3, B));  // pause at terminal count
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 1, 0, 3, B));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 2, 1, 3, B));  // step 1
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 2, 0, 3, B));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 2, 0, 3, B));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 3, 1, 3, B));  // step 2
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 3, 0, 3, B));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 4, 1, 3, B));  // step 3
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 4, 0, 3, B));  // step held
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 1, 3, B));
        vecs.push_back(mk(3, 1, 1, 1, 1, 0, 0, 0, 0, 3, B));  // no repeat
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 2, B));  // resume
        vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 1, 1, 2, B));
        vecs.push_back(mk(8, 0, 0, 0, 1, 0, 0, 1, 0, 2, B));  // back to slow
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 2, 1, 2, B));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 0, 1, B));  // done drops
        vecs.push_back(mk(10, 0, 0, 0, 0, 0, 0, 2, 0, 1, B));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 2, 0, 2, B));  // done returns
        vecs.push_back(mk(7, 0, 0, 0, 1, 0, 0, 2, 0, 2, B));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 3, 1, 2, B));

        reset = 1'b0; btn_fast = 1'b0; btn_pause = 1'b0; btn_step = 1'b0;
        page_sel = 1'b0; core_done = 1'b1; reg_data = 32'hDEAD_BEEF;
        run_edges(2);
        chk_all("reset", 1'b1, 3'd0, 1'b0, 2'd0, 16'h0000);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            btn_fast  = vecs[i].fast;
            btn_pause = vecs[i].pause;
            btn_step  = vecs[i].step;
            core_done = vecs[i].done;
            page_sel  = vecs[i].page;
            run_edges(vecs[i].n);
            chk_all($sformatf("v%0d", i), vecs[i].cr, vecs[i].addr, vecs[i].tick,
                    vecs[i].st, vecs[i].led);
        end

        // Asynchronous reset in the middle of RUN.
        run_edges(3);
        reset = 1'b0;
        #2;
        chk_all("midreset", 1'b1, 3'd0, 1'b0, 2'd0, 16'h0000);
        run_edges(2);
        reset = 1'b1;
        run_edges(1);
        chk_all("rel1", 1'b1, 3'd0, 1'b0, 2'd0, B);
        run_edges(1);
        chk_all("rel2", 1'b1, 3'd0, 1'b0, 2'd0, B);
        run_edges(1);
        chk_all("rel3", 1'b0, 3'd0, 1'b0, 2'd2, B);

        // Core not done at release: WAIT, then done with pause held goes to PAUSE.
        reset = 1'b0;
        core_done = 1'b0;
        run_edges(1);
        reset = 1'b1;
        run_edges(3);
        chk_all("wait", 1'b0, 3'd0, 1'b0, 2'd1, B);
        core_done = 1'b1;
        btn_pause = 1'b1;
        run_edges(1);
        chk_all("wait2pause", 1'b0, 3'd0, 1'b0, 2'd3, B);
        btn_pause = 1'b0;
        run_edges(1);
        chk_all("pause2run", 1'b0, 3'd0, 1'b0, 2'd2, B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
